// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator bank: operation encoding and controller states.
package acc_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_SHL = 3'd1;
  localparam logic [2:0] OP_SHR = 3'd2;
  localparam logic [2:0] OP_SAR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;
  localparam logic [2:0] OP_ROR = 3'd5;
  localparam logic [2:0] OP_INC = 3'd6;
  localparam logic [2:0] OP_DEC = 3'd7;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/acc_shift1.sv
// Single-bit shift/rotate of one accumulator word; the bit pushed out becomes the carry.
module acc_shift1
  import acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_cout
);

  // One step of the selected shift; non-shift ops pass the word through untouched.
  always_comb begin
    o_dout = i_din;
    o_cout = 1'b0;
    case (i_op)
      OP_SHL: begin
        o_dout = {i_din[WIDTH-2:0], 1'b0};
        o_cout = i_din[WIDTH-1];
      end
      OP_SHR: begin
        o_dout = {1'b0, i_din[WIDTH-1:1]};
        o_cout = i_din[0];
      end
      OP_SAR: begin
        o_dout = {i_din[WIDTH-1], i_din[WIDTH-1:1]};
        o_cout = i_din[0];
      end
      OP_ROL: begin
        o_dout = {i_din[WIDTH-2:0], i_din[WIDTH-1]};
        o_cout = i_din[WIDTH-1];
      end
      OP_ROR: begin
        o_dout = {i_din[0], i_din[WIDTH-1:1]};
        o_cout = i_din[0];
      end
      default: begin
        o_dout = i_din;
        o_cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/acc_bank.sv
// Bank of NREG accumulators with bus load/drive, in-place inc/dec and bit-serial shifts/rotates.
module acc_bank
  import acc_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 4,
  parameter  int SHW   = 3,
  localparam int SELW  = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [SELW-1:0]  sel,
  input  logic             la,
  input  logic             ea,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] acc_out_bus,
  output logic [WIDTH-1:0] acc_out_su,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             neg,
  output logic             carry
);

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]   ONE_SH = {{(SHW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_acc [NREG];
  state_t           r_state;
  logic [SELW-1:0]  r_idx;
  logic [2:0]       r_op;
  logic [SHW-1:0]   r_cnt;
  logic             r_carry;
  logic             r_done;

  logic [SELW-1:0]  w_idx;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_sh;
  logic             w_sh_c;

  // The latched index keeps the operand stable while sel wanders during a shift.
  assign w_idx = (r_state == SHIFT) ? r_idx : sel;
  assign w_cur = r_acc[w_idx];

  acc_shift1 #(.WIDTH(WIDTH)) u_shift1 (
    .i_op   (r_op),
    .i_din  (w_cur),
    .o_dout (w_sh),
    .o_cout (w_sh_c)
  );

  // Register file, controller state and carry flag.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_acc[i] <= {WIDTH{1'b0}};
      end
      r_state <= IDLE;
      r_idx   <= {SELW{1'b0}};
      r_op    <= OP_NOP;
      r_cnt   <= {SHW{1'b0}};
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (la) begin
            r_acc[w_idx] <= acc_in;
          end else if (start) begin
            case (op)
              OP_INC: begin
                r_acc[w_idx] <= w_cur + ONE_W;
                r_carry      <= &w_cur;
                r_done       <= 1'b1;
              end
              OP_DEC: begin
                r_acc[w_idx] <= w_cur - ONE_W;
                r_carry      <= ~|w_cur;
                r_done       <= 1'b1;
              end
              OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
                if (shamt == {SHW{1'b0}}) begin
                  r_done <= 1'b1;
                end else begin
                  r_idx   <= sel;
                  r_op    <= op;
                  r_cnt   <= shamt;
                  r_state <= SHIFT;
                end
              end
              default: begin
                r_done <= 1'b1;
              end
            endcase
          end else begin
            r_done <= 1'b0;
          end
        end
        SHIFT: begin
          // Saturation for long shifts falls out of simply repeating the one-bit step.
          r_acc[w_idx] <= w_sh;
          r_carry      <= w_sh_c;
          r_cnt        <= r_cnt - ONE_SH;
          if (r_cnt == ONE_SH) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= SHIFT;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign acc_out_bus = ea ? w_cur : {WIDTH{1'bz}};
  assign acc_out_su  = w_cur;
  assign zero        = (w_cur == {WIDTH{1'b0}});
  assign neg         = w_cur[WIDTH-1];
  assign busy        = (r_state == SHIFT);
  assign done        = r_done;
  assign carry       = r_carry;

endmodule
